k6502_sys_harness: RTL and testbench

- Synthesizable successor to the fixed CPU test wrapper: owns the memory map, CPU reset sequencing and run-length supervision for a k6502 core.
- Provides a parametrised RAM below the ROM window and a preloadable ROM in the upper half.
- Adds open-bus behaviour, CPU-reset stretching, cycle/fetch counters and a timeout halt, replacing the free-running stop timer.
- Sits between k6502 (a, d, rw, sync) and the top level or bench.

---
 rtl/k6502_sys_harness.sv | 264 ++++++++++++++++++++++++++
 tb/tb_k6502_sys_harness.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k6502_sys_harness.sv
// -----------------------------------------------------------------------------
// k6502_sys_harness
//
// System wrapper around a k6502 core. Owns the memory map (RAM below the ROM
// window, preloadable ROM in the upper half, open bus elsewhere), stretches the
// CPU reset after the system reset, counts RUN cycles and opcode fetches, and
// halts the CPU after a programmable number of RUN cycles.
//
// Optional feature macro: K6502_TRACE_EN
//   When defined, a 16-entry fetch-address trace FIFO and its ports are added.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   a          in   CPU address
//   din        in   CPU write data
//   rw         in   1 = read, 0 = write
//   sync       in   opcode-fetch strobe
//   dout       out  read data to the CPU (combinational)
//   cpu_rst_n  out  active-low CPU reset
//   rom_we     in   ROM preload strobe (honoured in every state, even in rst)
//   rom_waddr  in   ROM preload address
//   rom_wdata  in   ROM preload data
//   halt       out  run stopped by timeout
//   cycle_cnt  out  clk cycles spent in RUN (saturating)
//   fetch_cnt  out  sync-qualified fetches in RUN (wrapping)
//   trace_pop   in   (K6502_TRACE_EN) dequeue the head trace entry
//   trace_valid out  (K6502_TRACE_EN) trace FIFO non-empty
//   trace_addr  out  (K6502_TRACE_EN) head trace entry
//   trace_ovf   out  (K6502_TRACE_EN) sticky: a fetch was dropped while full
// -----------------------------------------------------------------------------
module k6502_sys_harness #(
  parameter int RAM_AW     = 11,
  parameter int ROM_AW     = 15,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       a,
  input  logic [7:0]        din,
  input  logic              rw,
  input  logic              sync,
  output logic [7:0]        dout,
  output logic              cpu_rst_n,
  input  logic              rom_we,
  input  logic [ROM_AW-1:0] rom_waddr,
  input  logic [7:0]        rom_wdata,
  output logic              halt,
  output logic [31:0]       cycle_cnt,
  output logic [15:0]       fetch_cnt
`ifdef K6502_TRACE_EN
  ,
  input  logic              trace_pop,
  output logic              trace_valid,
  output logic [15:0]       trace_addr,
  output logic              trace_ovf
`endif
);

  // RAM can never reach into the ROM window, so it is truncated at 0x7FFF.
  localparam int          RAM_EAW      = (RAM_AW > 15) ? 15 : RAM_AW;
  localparam int          RAM_DEPTH    = 1 << RAM_EAW;
  localparam int          ROM_DEPTH    = 1 << ROM_AW;
  localparam logic [16:0] RAM_LIMIT    = 17'(RAM_DEPTH);
  localparam logic [7:0]  HOLD_LAST    = 8'(RST_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] cycle_q, cycle_d;
  logic [15:0] fetch_q, fetch_d;
  logic [7:0]  ob_q, ob_d;        // open-bus latch: last byte on the data bus

  logic [7:0]  ram_q [RAM_DEPTH];
  logic [7:0]  rom_q [ROM_DEPTH];

  logic        rom_hit;
  logic        ram_hit;
  logic        ram_we;
  logic [7:0]  rd_data;

  // ---------------------------------------------------------------------------
  // Address decode and combinational read path
  // ---------------------------------------------------------------------------
  assign rom_hit = a[15];
  assign ram_hit = !a[15] && ({1'b0, a} < RAM_LIMIT);

  // NOTE: every signal driven in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = ob_q;
    if (rom_hit) begin
      rd_data = rom_q[a[ROM_AW-1:0]];
    end else if (ram_hit) begin
      rd_data = ram_q[a[RAM_EAW-1:0]];
    end
  end

  assign dout = rd_data;

  // ---------------------------------------------------------------------------
  // Run supervision FSM: next state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cycle_d = cycle_q;
    fetch_d = fetch_q;
    ob_d    = ob_q;
    ram_we  = 1'b0;

    unique case (state_q)
      ST_HOLD: begin
        hold_d = hold_q + 8'd1;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (cycle_q != 32'hFFFF_FFFF) begin
          cycle_d = cycle_q + 32'd1;
        end
        if (sync) begin
          fetch_d = fetch_q + 16'd1;
        end
        // Writes always drive din onto the bus, even when nothing is mapped;
        // unmapped reads leave the bus floating, so the latch keeps its value.
        if (!rw) begin
          ob_d   = din;
          ram_we = ram_hit;
        end else if (rom_hit || ram_hit) begin
          ob_d = rd_data;
        end
        if ((TIMEOUT != 0) && (cycle_q == TIMEOUT_LAST)) begin
          state_d = ST_HALT;
        end
      end

      ST_HALT: begin
        // Frozen until rst.
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // Decoding the state register directly means an asynchronous rst drops
  // cpu_rst_n at once, without waiting for a clock edge.
  assign cpu_rst_n = (state_q == ST_RUN);
  assign halt      = (state_q == ST_HALT);
  assign cycle_cnt = cycle_q;
  assign fetch_cnt = fetch_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      hold_q  <= 8'd0;
      cycle_q <= 32'd0;
      fetch_q <= 16'd0;
      ob_q    <= 8'hFF;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cycle_q <= cycle_d;
      fetch_q <= fetch_d;
      ob_q    <= ob_d;
    end
  end

  // NOTE: memory arrays carry no reset; clearing them would turn the RAMs
  // into flop arrays, and software must not rely on power-up contents.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q[a[RAM_EAW-1:0]] <= din;
    end
  end

  // Preload is independent of rst and of the FSM. The read path is
  // combinational on the pre-edge array, so a same-cycle read returns old data.
  always_ff @(posedge clk) begin
    if (rom_we) begin
      rom_q[rom_waddr] <= rom_wdata;
    end
  end

`ifdef K6502_TRACE_EN
  // ---------------------------------------------------------------------------
  // Fetch-address trace FIFO
  // ---------------------------------------------------------------------------
  logic [15:0] tr_mem_q [16];
  logic [3:0]  tr_wr_q, tr_wr_d;
  logic [3:0]  tr_rd_q, tr_rd_d;
  logic [4:0]  tr_cnt_q, tr_cnt_d;
  logic        tr_ovf_q, tr_ovf_d;
  logic        tr_push_req;
  logic        tr_push;
  logic        tr_pop;
  logic        tr_full;

  assign tr_full     = (tr_cnt_q == 5'd16);
  assign tr_pop      = trace_pop && (tr_cnt_q != 5'd0);
  assign tr_push_req = (state_q == ST_RUN) && sync;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
  assign tr_push     = tr_push_req && (!tr_full || tr_pop);

  always_comb begin
    tr_wr_d  = tr_wr_q;
    tr_rd_d  = tr_rd_q;
    tr_cnt_d = tr_cnt_q;
    tr_ovf_d = tr_ovf_q;
    if (tr_push) begin
      tr_wr_d = tr_wr_q + 4'd1;
    end
    if (tr_pop) begin
      tr_rd_d = tr_rd_q + 4'd1;
    end
    if (tr_push && !tr_pop) begin
      tr_cnt_d = tr_cnt_q + 5'd1;
    end else if (!tr_push && tr_pop) begin
      tr_cnt_d = tr_cnt_q - 5'd1;
    end
    if (tr_push_req && !tr_push) begin
      tr_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tr_wr_q  <= 4'd0;
      tr_rd_q  <= 4'd0;
      tr_cnt_q <= 5'd0;
      tr_ovf_q <= 1'b0;
    end else begin
      tr_wr_q  <= tr_wr_d;
      tr_rd_q  <= tr_rd_d;
      tr_cnt_q <= tr_cnt_d;
      tr_ovf_q <= tr_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tr_push) begin
      tr_mem_q[tr_wr_q] <= a;
    end
  end

  assign trace_valid = (tr_cnt_q != 5'd0);
  assign trace_addr  = tr_mem_q[tr_rd_q];
  assign trace_ovf   = tr_ovf_q;
`endif

endmodule

// File: tb/tb_k6502_sys_harness.sv
// -----------------------------------------------------------------------------
// tb_k6502_sys_harness
//
// Self-checking bench for k6502_sys_harness with default parameters. Stimulus
// is randomised; expectations come from a behavioural model that tracks RAM,
// ROM and open-bus contents as arrays and the run phase as plain counts of
// edges since reset and RUN cycles. Optional trace checks under K6502_TRACE_EN.
// -----------------------------------------------------------------------------
module tb_k6502_sys_harness;

  localparam int RAM_AW     = 11;
  localparam int RAM_SIZE   = 1 << RAM_AW;
  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 40;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [7:0]  din;
  logic        rw;
  logic        sync;
  logic [7:0]  dout;
  logic        cpu_rst_n;
  logic        rom_we;
  logic [14:0] rom_waddr;
  logic [7:0]  rom_wdata;
  logic        halt;
  logic [31:0] cycle_cnt;
  logic [15:0] fetch_cnt;
`ifdef K6502_TRACE_EN
  logic        trace_pop;
  logic        trace_valid;
  logic [15:0] trace_addr;
  logic        trace_ovf;
`endif

  k6502_sys_harness #(
    .RAM_AW    (RAM_AW),
    .ROM_AW    (15),
    .RST_CYCLES(RST_CYCLES),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .din       (din),
    .rw        (rw),
    .sync      (sync),
    .dout      (dout),
    .cpu_rst_n (cpu_rst_n),
    .rom_we    (rom_we),
    .rom_waddr (rom_waddr),
    .rom_wdata (rom_wdata),
    .halt      (halt),
    .cycle_cnt (cycle_cnt),
    .fetch_cnt (fetch_cnt)
`ifdef K6502_TRACE_EN
    ,
    .trace_pop  (trace_pop),
    .trace_valid(trace_valid),
    .trace_addr (trace_addr),
    .trace_ovf  (trace_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  ram_m [RAM_SIZE];
  bit          ram_k [RAM_SIZE];
  logic [7:0]  rom_m [32768];
  bit          rom_k [32768];
  logic [7:0]  ob_m;
  bit          ob_k;
  int          edges;      // clock edges seen with rst low since the last reset
  int          runc;       // RUN cycles completed since the last reset
  int          fetch_m;
  logic [15:0] tq [$];
  bit          ovf_m;

  function automatic bit run_m();
    return (edges >= RST_CYCLES) && !((TIMEOUT != 0) && (runc >= TIMEOUT));
  endfunction

  function automatic bit halt_m();
    return (edges >= RST_CYCLES) && (TIMEOUT != 0) && (runc >= TIMEOUT);
  endfunction

  task automatic rd_m(input logic [15:0] ad, output logic [7:0] v, output bit k,
                      output bit mapped);
    mapped = 1'b1;
    if (ad[15]) begin
      v = rom_m[ad[14:0]];
      k = rom_k[ad[14:0]];
    end else if (int'(ad) < RAM_SIZE) begin
      v = ram_m[ad[RAM_AW-1:0]];
      k = ram_k[ad[RAM_AW-1:0]];
    end else begin
      v      = ob_m;
      k      = ob_k;
      mapped = 1'b0;
    end
  endtask

  task automatic model_reset();
    edges   = 0;
    runc    = 0;
    fetch_m = 0;
    ob_m    = 8'hFF;
    ob_k    = 1'b1;
    tq.delete();
    ovf_m   = 1'b0;
  endtask

  // Called at posedge+1 with inputs just applied: let them settle, compare.
  task automatic settle();
    logic [7:0] v;
    bit         k;
    bit         m;
    #2;
    rd_m(a, v, k, m);
    if (k) check("dout", 32'(dout), 32'(v));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(run_m()));
    check("halt", 32'(halt), 32'(halt_m()));
    check("cycle_cnt", cycle_cnt, 32'(runc));
    check("fetch_cnt", 32'(fetch_cnt), 32'(fetch_m & 16'hFFFF));
`ifdef K6502_TRACE_EN
    check("trace_valid", 32'(trace_valid), 32'(tq.size() != 0));
    if (tq.size() != 0) check("trace_addr", 32'(trace_addr), 32'(tq[0]));
    check("trace_ovf", 32'(trace_ovf), 32'(ovf_m));
`endif
  endtask

  // Advance one clock edge and apply its effect to the model.
  task automatic clock_edge();
    logic [7:0] v;
    bit         k;
    bit         m;
    bit         run;
    @(posedge clk);
    #1;
    if (!rst) begin
      run = run_m();
      rd_m(a, v, k, m);
      if (run) begin
        if (!rw) begin
          if (int'(a) < RAM_SIZE) begin
            ram_m[a[RAM_AW-1:0]] = din;
            ram_k[a[RAM_AW-1:0]] = 1'b1;
          end
          ob_m = din;
          ob_k = 1'b1;
        end else if (m) begin
          ob_m = v;
          ob_k = k;
        end
        runc++;
        if (sync) fetch_m++;
      end
`ifdef K6502_TRACE_EN
      if (trace_pop && tq.size() != 0) void'(tq.pop_front());
      if (run && sync) begin
        if (tq.size() < 16) tq.push_back(a);
        else ovf_m = 1'b1;
      end
`endif
      edges++;
    end
    if (rom_we) begin
      rom_m[rom_waddr] = rom_wdata;
      rom_k[rom_waddr] = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1:    return 16'($urandom_range(0, 31));
      2:       return 16'(16'h07F8 + $urandom_range(0, 15));   // RAM top / unmapped
      3:       return 16'(16'h0800 + $urandom_range(0, 16'h77FF));
      4:       return 16'(16'hFFF0 + $urandom_range(0, 15));
      5:       return 16'(16'h8000 + $urandom_range(0, 15));
      default: return 16'hC000;
    endcase
  endfunction

  function automatic logic [14:0] rom_pool();
    int idx;
    idx = int'($urandom_range(0, 32));
    if (idx < 16) return 15'(15'h7FF0 + idx);
    if (idx < 32) return 15'(idx - 16);
    return 15'h4000;
  endfunction

  // mode: 0 = low, 1 = high, 2 = random
  task automatic rand_cycle(input int sync_mode, input int pop_mode);
    a         = rand_addr();
    rw        = 1'($urandom_range(0, 1));
    din       = 8'($urandom);
    sync      = (sync_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(sync_mode);
    rom_we    = ($urandom_range(0, 3) == 0);
    rom_wdata = 8'($urandom);
    // Half the ROM-read cycles also preload the word being read.
    if (a[15] && ($urandom_range(0, 1) == 1)) rom_waddr = a[14:0];
    else rom_waddr = rom_pool();
`ifdef K6502_TRACE_EN
    trace_pop = (pop_mode == 2) ? ($urandom_range(0, 2) == 0) : 1'(pop_mode);
`else
    if (pop_mode < 0) rw = 1'b1;
`endif
    settle();
    clock_edge();
  endtask

  task automatic op(input logic [15:0] ad, input logic r, input logic [7:0] d);
    a      = ad;
    rw     = r;
    din    = d;
    sync   = r;
    rom_we = 1'b0;
`ifdef K6502_TRACE_EN
    trace_pop = 1'b0;
`endif
    settle();
  endtask

  task automatic sys_reset(input int n);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) rand_cycle(2, 2);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    a         = 16'h4000;
    din       = 8'h00;
    rw        = 1'b1;
    sync      = 1'b0;
    rom_we    = 1'b0;
    rom_waddr = '0;
    rom_wdata = '0;
`ifdef K6502_TRACE_EN
    trace_pop = 1'b0;
`endif
    for (int i = 0; i < RAM_SIZE; i++) ram_k[i] = 1'b0;
    for (int i = 0; i < 32768; i++) rom_k[i] = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset values, open-bus latch visible on an unmapped address.
    settle();
    check("rst_ob", 32'(dout), 32'h0000_00FF);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);

    // Preload ROM while rst is held: vectors, a small pool and 0xC000.
    for (int i = 0; i < 33; i++) begin
      rom_we = 1'b1;
      if (i < 16) begin
        rom_waddr = 15'(15'h7FF0 + i);
        rom_wdata = (i == 12) ? 8'h00 : (i == 13) ? 8'h80 : 8'($urandom);
      end else if (i < 32) begin
        rom_waddr = 15'(i - 16);
        rom_wdata = 8'($urandom);
      end else begin
        rom_waddr = 15'h4000;
        rom_wdata = 8'hC3;
      end
      settle();
      clock_edge();
    end
    rom_we = 1'b0;

    // Run 1: reset stretch, directed map checks, timeout.
    rst = 1'b0;
    for (int i = 0; i < RST_CYCLES; i++) begin
      settle();
      check("hold_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("hold_cycle_cnt", cycle_cnt, 32'd0);
      clock_edge();
    end
    op(16'hFFFC, 1'b1, 8'h00);
    check("run_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("rom_vec_lo", 32'(dout), 32'h00);
    clock_edge();
    op(16'hFFFD, 1'b1, 8'h00); check("rom_vec_hi", 32'(dout), 32'h80); clock_edge();
    op(16'h0010, 1'b0, 8'h5A); clock_edge();
    op(16'h0010, 1'b1, 8'h00); check("ram_rd", 32'(dout), 32'h5A); clock_edge();
    op(16'h4000, 1'b1, 8'h00); check("ob_after_rd", 32'(dout), 32'h5A); clock_edge();
    op(16'hC000, 1'b0, 8'h33); clock_edge();
    op(16'h4000, 1'b1, 8'h00); check("ob_after_wr", 32'(dout), 32'h33); clock_edge();
    op(16'hC000, 1'b1, 8'h00); check("rom_unchanged", 32'(dout), 32'hC3); clock_edge();
    for (int i = 0; i < TIMEOUT - 8; i++) rand_cycle(2, 2);
    op(16'h0010, 1'b1, 8'h00);
    check("timeout_halt", 32'(halt), 32'd1);
    check("timeout_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("timeout_cycle_cnt", cycle_cnt, 32'd40);
    clock_edge();
    op(16'h0010, 1'b0, 8'h00);
    clock_edge();
    op(16'h0010, 1'b1, 8'h00);
    check("halt_wr_ignored", 32'(dout), 32'(ram_m[16]));
    clock_edge();
    for (int i = 0; i < 10; i++) rand_cycle(2, 2);
    check("halt_cycle_hold", cycle_cnt, 32'd40);

    // Run 2: asynchronous reset 10 cycles into RUN.
    sys_reset(2);
    for (int i = 0; i < RST_CYCLES + 10; i++) rand_cycle(2, 2);
    check("pre_async_run", 32'(cpu_rst_n), 32'd1);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("async_cycle_cnt", cycle_cnt, 32'd0);
    check("async_fetch_cnt", 32'(fetch_cnt), 32'd0);
    check("async_halt", 32'(halt), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) rand_cycle(2, 2);
    rst = 1'b0;

    // Run 3: 18 fetches without pop, then drain.
    for (int i = 0; i < RST_CYCLES; i++) rand_cycle(0, 0);
    for (int i = 0; i < 18; i++) rand_cycle(1, 0);
`ifdef K6502_TRACE_EN
    begin
      int npop;
      npop = 0;
      check("trace_ovf_set", 32'(trace_ovf), 32'd1);
      for (int i = 0; i < 18; i++) begin
        if (trace_valid) npop++;
        rand_cycle(0, 1);
      end
      check("trace_pop_count", 32'(npop), 32'd16);
    end
`else
    for (int i = 0; i < 18; i++) rand_cycle(0, 1);
`endif
    for (int i = 0; i < 10; i++) rand_cycle(2, 2);

    // Runs 4-6: fully random.
    for (int r = 0; r < 3; r++) begin
      sys_reset(int'($urandom_range(1, 3)));
      for (int i = 0; i < RST_CYCLES + TIMEOUT + 12; i++) rand_cycle(2, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
